// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
//   btn_state_t : per-channel debounce FSM state
//   clog2_max   : counter width able to hold the largest of three cycle counts
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_t;

  // Width needed to represent 0..max(a, b, c) without wrapping.
  function automatic int unsigned clog2_max(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of button pins and conditioned outputs.
//   btn_raw       : raw, asynchronous button pins (driven by the board side)
//   level         : debounced pressed state, 1 = pressed
//   press_pulse   : one-cycle strobe on accepted press and on each auto-repeat
//   release_pulse : one-cycle strobe on accepted release
// master: the board/environment side; slave: the conditioner.
interface button_conditioner_if #(
  parameter int unsigned N_CH = 2
);

  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;

  modport master (
    output btn_raw,
    input  level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn_raw,
    output level,
    output press_pulse,
    output release_pulse
  );

endinterface

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, polarity fix-up, counter-based
// debounce FSM, optional auto-repeat, registered level and strobes.
//   Clk           : system clock, rising edge
//   Reset         : synchronous, active-high
//   btn_raw       : raw asynchronous pin
//   level         : debounced pressed state (1 = pressed)
//   press_pulse   : one-cycle strobe on accepted press and each repeat
//   release_pulse : one-cycle strobe on accepted release
// Auto-repeat assumes REPEAT_PERIOD <= REPEAT_DELAY so the reload value is
// non-negative.
module button_channel
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CW = clog2_max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CW-1:0] CntLast   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RptLast   = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RptReload = CW'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [CW-1:0] CntOne    = CW'(1);

  // The pin reads ACTIVE_LOW when released.
  localparam logic Inactive = ACTIVE_LOW;

  logic          s1_q;
  logic          s2_q;
  btn_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] timer_q;
  logic          press_evt_q;
  logic          release_evt_q;
  logic          p;

  // p = 1 means the synchronised pin says "pressed".
  assign p = s2_q ^ ACTIVE_LOW;

  // The FSM decides an event on one edge (press_evt_q/release_evt_q) and the
  // output stage presents it on the next, so level and both strobes come
  // straight from flops and move together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q          <= Inactive;
      s2_q          <= Inactive;
      state_q       <= IDLE;
      cnt_q         <= '0;
      timer_q       <= '0;
      press_evt_q   <= 1'b0;
      release_evt_q <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;

      level         <= (state_q == HELD) || (state_q == ARM_RELEASE);
      press_pulse   <= press_evt_q;
      release_pulse <= release_evt_q;

      press_evt_q   <= 1'b0;
      release_evt_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (p) begin
            // With a single-sample debounce the first pressed sample is
            // already the accepting one.
            if (DEBOUNCE_CYCLES == 1) begin
              state_q     <= HELD;
              cnt_q       <= '0;
              timer_q     <= '0;
              press_evt_q <= 1'b1;
            end else begin
              state_q <= ARM_PRESS;
              cnt_q   <= CntOne;
            end
          end
        end

        ARM_PRESS: begin
          if (!p) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q     <= HELD;
            cnt_q       <= '0;
            timer_q     <= '0;
            press_evt_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        HELD: begin
          if (!p) begin
            timer_q <= '0;
            if (DEBOUNCE_CYCLES == 1) begin
              state_q       <= IDLE;
              cnt_q         <= '0;
              release_evt_q <= 1'b1;
            end else begin
              state_q <= ARM_RELEASE;
              cnt_q   <= CntOne;
            end
          end else if (REPEAT_EN) begin
            // Reload instead of clearing so the following repeats are
            // REPEAT_PERIOD apart while reusing the single DELAY compare.
            if (timer_q == RptLast) begin
              press_evt_q <= 1'b1;
              timer_q     <= RptReload;
            end else begin
              timer_q <= timer_q + CntOne;
            end
          end
        end

        ARM_RELEASE: begin
          if (p) begin
            // Bounce during release: back to held with a fresh repeat delay,
            // no new press strobe.
            state_q <= HELD;
            cnt_q   <= '0;
            timer_q <= '0;
          end else if (cnt_q == CntLast) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            release_evt_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end. Each channel is synchronised,
// polarity-corrected, debounced and turned into a registered level plus
// one-cycle press/release strobes; channels selected by REPEAT_MASK also
// auto-repeat their press strobe while held.
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : slave side of button_conditioner_if (btn_raw in; level,
//           press_pulse, release_pulse out), N_CH bits each
module button_conditioner #(
  parameter int unsigned     N_CH            = 2,
  parameter bit              ACTIVE_LOW      = 1'b1,
  parameter int unsigned     DEBOUNCE_CYCLES = 16,
  parameter logic [N_CH-1:0] REPEAT_MASK     = '0,
  parameter int unsigned     REPEAT_DELAY    = 64,
  parameter int unsigned     REPEAT_PERIOD   = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  button_conditioner_if.slave  bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .Clk           (Clk),
      .Reset         (Reset),
      .btn_raw       (bus.btn_raw[i]),
      .level         (bus.level[i]),
      .press_pulse   (bus.press_pulse[i]),
      .release_pulse (bus.release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (active-low with 4-sample
// debounce and repeat on channel 0; active-high with 1-sample debounce).
// Expected strobes come from a sample-stream model of the button behaviour
// and are queued per channel; a monitor pops and compares every cycle.
module tb_button_conditioner;

  localparam int RD = 8;
  localparam int RP = 3;

  typedef enum logic [1:0] {EvPress, EvRepeat, EvRelease, EvReset} ev_kind_t;
  typedef struct {
    int       t;
    ev_kind_t kind;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_conditioner_if #(.N_CH(2)) bus0 ();
  button_conditioner_if #(.N_CH(2)) bus1 ();

  button_conditioner #(
    .N_CH(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .REPEAT_MASK(2'b01),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut0 (
    .Clk(clk), .Reset(reset), .bus(bus0)
  );

  button_conditioner #(
    .N_CH(2), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(1), .REPEAT_MASK(2'b00),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut1 (
    .Clk(clk), .Reset(reset), .bus(bus1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus in "pressed" terms; pins derived per instance polarity.
  logic [1:0] press_st [2];
  bit         rst_st;

  // Model state per queue q = inst*2 + ch.
  ev_t exp_q [4][$];
  bit  m_lvl    [4];
  int  m_run    [4];
  int  m_streak [4];
  bit  m_prev   [4];
  bit  mon_lvl  [4];

  function automatic int deb_of(input int q);
    return (q < 2) ? 4 : 1;
  endfunction

  // Raw sample taken at edge k shows up on the outputs after edge k+3.
  task automatic model_sample(input int k);
    for (int q = 0; q < 4; q++) begin
      bit pr;
      pr = press_st[q / 2][q % 2];
      if (rst_st) begin
        while (exp_q[q].size() > 0 && exp_q[q][exp_q[q].size() - 1].t >= k)
          void'(exp_q[q].pop_back());
        exp_q[q].push_back('{t: k, kind: EvReset});
        m_lvl[q] = 0; m_run[q] = 0; m_streak[q] = 0; m_prev[q] = 0;
      end else if (!m_lvl[q]) begin
        m_run[q] = pr ? m_run[q] + 1 : 0;
        if (m_run[q] == deb_of(q)) begin
          m_lvl[q] = 1; m_run[q] = 0; m_streak[q] = 0; m_prev[q] = 1;
          exp_q[q].push_back('{t: k + 3, kind: EvPress});
        end
      end else if (pr) begin
        m_run[q] = 0;
        m_streak[q] = m_prev[q] ? m_streak[q] + 1 : 0;
        m_prev[q] = 1;
        if (q == 0 && m_streak[q] >= RD && ((m_streak[q] - RD) % RP) == 0)
          exp_q[q].push_back('{t: k + 3, kind: EvRepeat});
      end else begin
        m_prev[q] = 0;
        m_run[q] = m_run[q] + 1;
        if (m_run[q] == deb_of(q)) begin
          m_lvl[q] = 0; m_run[q] = 0;
          exp_q[q].push_back('{t: k + 3, kind: EvRelease});
        end
      end
    end
  endtask

  task automatic step();
    bus0.btn_raw = ~press_st[0];
    bus1.btn_raw = press_st[1];
    reset = rst_st;
    model_sample(cyc + 1);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input int q, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s inst%0d ch%0d cycle %0d: got %b want %b",
               name, q / 2, q % 2, cyc, got, want);
    end
  endtask

  // Monitor: outputs registered at edge cyc are checked on the following negedge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int q = 0; q < 4; q++) begin
        logic gp, gr, gl;
        bit   sp, sr;
        ev_t  e;
        if (q < 2) begin
          gp = bus0.press_pulse[q]; gr = bus0.release_pulse[q]; gl = bus0.level[q];
        end else begin
          gp = bus1.press_pulse[q - 2]; gr = bus1.release_pulse[q - 2];
          gl = bus1.level[q - 2];
        end
        sp = 0; sr = 0;
        while (exp_q[q].size() > 0 && exp_q[q][0].t <= cyc) begin
          e = exp_q[q].pop_front();
          if (e.t < cyc) begin
            n_cmp++; n_err++;
            $display("FAIL missed_event inst%0d ch%0d cycle %0d: got none want kind %0d at %0d",
                     q / 2, q % 2, cyc, e.kind, e.t);
          end else begin
            case (e.kind)
              EvPress:   begin sp = 1; mon_lvl[q] = 1; end
              EvRepeat:  sp = 1;
              EvRelease: begin sr = 1; mon_lvl[q] = 0; end
              default:   mon_lvl[q] = 0;
            endcase
          end
        end
        check("press_pulse", q, gp, sp);
        check("release_pulse", q, gr, sr);
        check("level", q, gl, mon_lvl[q]);
      end
    end
  end

  int dur [4];

  initial begin
    press_st[0] = 2'b00;
    press_st[1] = 2'b00;
    rst_st = 1;
    run(3);
    rst_st = 0;
    run(4);

    // Clean press and release on channel 0 of both instances.
    press_st[0][0] = 1; press_st[1][0] = 1; run(20);
    press_st[0][0] = 0; press_st[1][0] = 0; run(20);

    // Bounce shorter than the debounce window.
    press_st[0][0] = 1; run(3);
    press_st[0][0] = 0; run(1);
    press_st[0][0] = 1; run(3);
    press_st[0][0] = 0; run(12);

    // Both channels together, long hold (repeat on inst0 ch0), staggered release.
    press_st[0] = 2'b11; press_st[1] = 2'b11; run(40);
    press_st[0][1] = 0; press_st[1][1] = 0; run(6);
    press_st[0][0] = 0; press_st[1][0] = 0; run(15);

    // Reset in the middle of a hold.
    press_st[0][0] = 1; press_st[1][0] = 1; run(15);
    rst_st = 1; run(2);
    rst_st = 0; run(20);
    press_st[0][0] = 0; press_st[1][0] = 0; run(15);

    // Random hold/bounce durations with occasional resets.
    for (int q = 0; q < 4; q++) dur[q] = $urandom_range(1, 6);
    for (int c = 0; c < 1500; c++) begin
      for (int q = 0; q < 4; q++) begin
        if (dur[q] == 0) begin
          press_st[q / 2][q % 2] = ~press_st[q / 2][q % 2];
          dur[q] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40)
                                               : $urandom_range(1, 6);
        end else begin
          dur[q]--;
        end
      end
      rst_st = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_st = 0;

    // Drain: release everything and let pending strobes come out.
    press_st[0] = 2'b00; press_st[1] = 2'b00;
    run(20);
    for (int q = 0; q < 4; q++) begin
      n_cmp++;
      if (exp_q[q].size() != 0) begin
        n_err++;
        $display("FAIL leftover_events inst%0d ch%0d: got %0d pending want 0",
                 q / 2, q % 2, exp_q[q].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel front end for the board push-buttons that drive Run, Continue and Reset-style controls into the processor top level.
- Per channel:
  - two-flop synchroniser
  - optional polarity inversion
  - counter-based debounce
  - one-cycle press and release strobes
- Optional per-channel auto-repeat turns a held button into a periodic press-strobe train, for single-step and continue handling.

Parameters:
- N_CH, 2, number of independent button channels.
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a change; must be >= 1.
- REPEAT_MASK, {N_CH{1'b0}}, bit i = 1 enables auto-repeat on channel i.
- REPEAT_DELAY, 64, cycles from accepted press to first repeat strobe; must be >= 1.
- REPEAT_PERIOD, 16, cycles between subsequent repeat strobes; must be >= 2.

Ports:
- Clk, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, synchronous, active-high reset.
- btn_raw, input, N_CH, asynchronous raw button pins.
- level, output, N_CH, debounced pressed state; 1 = pressed, regardless of ACTIVE_LOW.
- press_pulse, output, N_CH, one-cycle strobe on accepted press and on each auto-repeat.
- release_pulse, output, N_CH, one-cycle strobe on accepted release.

Behaviour:
- Reset (sampled high at an edge):
  - level, press_pulse and release_pulse are all 0.
  - Both synchroniser flops load the inactive pin value (1 if ACTIVE_LOW, else 0).
  - Every channel FSM goes to IDLE; debounce and repeat counters are cleared.
- Reset mid-operation: a button still held when Reset deasserts must be re-debounced from scratch and then produces a fresh press_pulse.
- Synchroniser: btn_raw -> s1 -> s2 on successive edges. Let p = s2 XOR ACTIVE_LOW, so p = 1 means pressed.
- Per-channel FSM, states IDLE, ARM_PRESS, HELD, ARM_RELEASE:
  - IDLE (level = 0):
    - p = 1 -> ARM_PRESS, debounce counter cnt = 1.
  - ARM_PRESS (level = 0):
    - p = 0 -> IDLE, cnt = 0 (bounce rejected, no strobe).
    - p = 1 and cnt == DEBOUNCE_CYCLES-1 -> HELD; registered level = 1 and press_pulse = 1 for exactly that following cycle.
    - Otherwise cnt++.
  - HELD (level = 1):
    - p = 0 -> ARM_RELEASE, cnt = 1, repeat timer cleared.
    - If REPEAT_MASK[i] = 1, the repeat timer counts cycles since the press strobe:
      - press_pulse = 1 when the timer reaches REPEAT_DELAY.
      - Thereafter press_pulse = 1 every REPEAT_PERIOD cycles while the FSM remains in HELD.
  - ARM_RELEASE (level = 1):
    - p = 1 -> HELD. The repeat timer restarts from 0, so the next repeat comes REPEAT_DELAY cycles later. No new press strobe.
    - p = 0 and cnt == DEBOUNCE_CYCLES-1 -> IDLE; level = 0 and release_pulse = 1 for one cycle.
    - Otherwise cnt++.
- DEBOUNCE_CYCLES = 1: ARM_PRESS and ARM_RELEASE are single-cycle; a change is accepted after one stable sample.
- Latency: raw change set up before edge 0 -> level/press_pulse high after edge DEBOUNCE_CYCLES+2; release timing is symmetric.
- press_pulse and release_pulse on the same channel are never high in the same cycle. No repeat strobe is issued once release_pulse fires.
- Channels are fully independent; simultaneous events on several channels all produce their strobes in the same cycle.
- Counter widths: $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). Counters never wrap:
  - the debounce counter stops at its terminal value;
  - the repeat timer reloads to REPEAT_DELAY-REPEAT_PERIOD after each repeat strobe.
- All outputs are registered; there are no combinational paths from btn_raw.

Decomposition:
- Package btn_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, ARM_PRESS, HELD, ARM_RELEASE};
  - function clog2_max for counter sizing.
- Sub-module button_channel: one synchroniser + FSM + counters, with scalar ports. It takes parameters ACTIVE_LOW, DEBOUNCE_CYCLES, REPEAT_EN, REPEAT_DELAY, REPEAT_PERIOD.
- button_conditioner instantiates button_channel N_CH times via generate, passing REPEAT_MASK[i] as REPEAT_EN.

Test Plan:
- Clean press and release (N_CH=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, no repeat):
  - btn_raw[0] 1->0 before edge 0 -> level[0] and press_pulse[0] high after edge 6; press_pulse[0] high for one cycle only; channel 1 outputs stay 0.
  - btn_raw[0] 0->1 -> release_pulse[0] one cycle, level[0] low, same 6-edge latency.
- Bounce rejection: btn_raw[0] low for 3 cycles, high for 1, low for 3, then high -> no press_pulse, level[0] stays 0.
- Auto-repeat (REPEAT_MASK=2'b01, REPEAT_DELAY=8, REPEAT_PERIOD=3): hold btn_raw[0] low for 30 cycles after the press strobe at cycle T -> press_pulse[0] at T, T+8, T+11, T+14, ... until release. The same hold on channel 1 gives a single strobe.
- Simultaneous channels: both buttons pressed at the same edge -> press_pulse == 2'b11 in the same cycle; staggered releases give separate release_pulse bits.
- Reset mid-hold: Reset=1 for 2 cycles while btn_raw[0] is held low -> all outputs 0 during and after reset; fresh press_pulse[0] DEBOUNCE_CYCLES+2 edges after Reset deasserts.
- Polarity (ACTIVE_LOW=0): btn_raw[0] 0->1 -> press_pulse[0] with the same latency. Reset leaves the synchroniser at 0, so no spurious press_pulse after reset.
